alu_multicycle: RTL and testbench
=================================

# alu_multicycle

Parametrised, clocked successor to the processor's combinational ALU. It keeps the same 4-bit operation encoding and zero-flag semantics. It adds a valid/ready handshake, a configurable datapath width, a full-width multiply high word, and a divide remainder. Multiply and divide run as iterative units: one bit per cycle, radix-2. The block sits in the EX stage: the pipeline control stalls on `in_ready`/`out_valid` instead of relying on single-cycle `*` and `/`.

## Interface
- `WIDTH`, 32: operand/result width in bits, ≥ 4.
- `CNT_W`, $clog2(WIDTH+1): iteration counter width (derived, not overridden).

- `clk`  in  1: clock, rising edge.
- `rst_n`  in  1: asynchronous active-low reset.
- `in_valid`  in  1: operation request.
- `in_ready`  out  1: high only in IDLE; request accepted when `in_valid && in_ready` at a rising edge.
- `alu_control`  in  4: opcode, sampled at accept.
- `in_a`, `in_b`  in  WIDTH: unsigned operands, sampled at accept.
- `out_valid`  out  1: result held stable until accepted.
- `out_ready`  in  1: consumer accepts the result when `out_valid && out_ready`.
- `result`  out  WIDTH: main result (quotient / product low word / ALU result).
- `result_hi`  out  WIDTH: product high word or remainder; 0 for other ops.
- `zero`  out  1: `result == 0`, registered together with `result`.
- `div_by_zero`  out  1: set when a divide had `in_b == 0`.
- `busy`  out  1: high in MUL or DIV.

## Operation
- Opcodes: 0000 DIV, 0001 MUL, 0010 SUB, 0011 ADD, 0100 OR, 0101 AND, 0110 NE, 0111 GT, 1000 LT, 1001–1111 invalid (`result` 0).
- Compare ops (NE/GT/LT): `result` = 0 when the condition is true, 1 when false. `zero` is therefore the branch-taken flag.
- All arithmetic is unsigned. ADD/SUB wrap modulo 2^WIDTH with no carry/overflow output.
- MUL produces a 2·WIDTH product: low word on `result`, high word on `result_hi`.
- DIV: `result` = a / b, `result_hi` = a % b.
- Divide by zero: `result` = all ones, `result_hi` = `in_a`, `div_by_zero` = 1. The op completes with single-cycle latency and does not enter DIV.
- FSM states: IDLE, MUL, DIV, DONE.
  - IDLE → DONE: single-cycle op or divide by zero; outputs are registered at the accept edge.
  - IDLE → MUL / DIV: operands are loaded and the counter is set to WIDTH.
  - MUL / DIV → DONE: at the edge where the counter reaches 0 (the WIDTH-th iteration).
  - DONE → IDLE: at the `out_valid && out_ready` edge.
- MUL iteration: shift-add on {acc, multiplier}, one multiplier bit per cycle, LSB first.
- DIV iteration: restoring division; shift {rem, quot} left, trial-subtract b, set the quotient bit if no borrow.
- `in_valid` during MUL, DIV or DONE is ignored; the requester must hold it.
- `result`, `result_hi`, `zero` and `div_by_zero` change only on the edge entering DONE. They are held through DONE and IDLE until the next completion.
- Reset at any time, including mid-iteration: the state returns to IDLE and the operation in flight is discarded with no output.

## Timing
- Reset values: `out_valid` 0, `busy` 0, `in_ready` 1, `result` 0, `result_hi` 0, `zero` 1, `div_by_zero` 0.
- `in_ready`, `out_valid` and `busy` are decoded directly from state registers, with no combinational path from inputs.
- Single-cycle ops, and DIV with b = 0: accepted at edge k, `out_valid` high after edge k.
- MUL/DIV: accepted at edge k, iterations at edges k+1..k+WIDTH, `out_valid` high after edge k+WIDTH.
- `out_valid` accepted at edge m: `in_ready` high after edge m, next accept at edge m+1 at the earliest. Peak throughput is therefore one op per 2 cycles.
- `out_ready` held high while waiting: DONE lasts exactly one cycle.

## Structure
- `alu_pkg`:
  - `alu_op_t` enum of the 4-bit opcodes above.
  - `alu_state_t` enum {IDLE, MUL, DIV, DONE}.
  - Localparams for the compare true/false result values.
- Sub-module `alu_muldiv_iter`:
  - Holds the shared {hi, lo} shift register, counter and mode bit.
  - Ports: `load`, `mode`, `a`, `b`, `last`, `hi`, `lo`.
- The top level keeps the FSM, the single-cycle datapath and the output registers.

## Test plan
- Reset, then ADD 0xFFFFFFFF + 2 with `out_ready` = 1: `out_valid` one cycle after accept, `result` = 0x00000001, `zero` = 0, `result_hi` = 0.
- MUL 0xFFFFFFFF × 0xFFFFFFFF: `busy` for 32 cycles, then `result` = 0x00000001, `result_hi` = 0xFFFFFFFE.
- DIV 100 / 7: `result` = 14, `result_hi` = 2, `div_by_zero` = 0, latency 32. Then DIV 5 / 0: `result` = 0xFFFFFFFF, `result_hi` = 5, `div_by_zero` = 1, latency 1.
- Compares:
  - NE 3, 3: `result` = 1, `zero` = 0.
  - GT 9, 3: `result` = 0, `zero` = 1.
  - LT 9, 3: `result` = 1.
  - Opcode 1111: `result` = 0, `zero` = 1.
- Backpressure: hold `out_ready` = 0 for 5 cycles after a MUL completes; outputs stay stable and `in_ready` = 0 throughout, and a new `in_valid` is not accepted until one cycle after the handshake.
- Assert `rst_n` = 0 at iteration 10 of a DIV: all outputs return to reset values immediately; after release, ADD 1 + 1 gives `result` = 2 with no stale DIV completion.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types and constants for the multi-cycle ALU: opcode and FSM state
// encodings, compare result values and the mul/div unit mode select.
package alu_pkg;

    // 4-bit opcodes, same encoding as the combinational ALU this block replaces.
    typedef enum logic [3:0] {
        OP_DIV = 4'b0000,
        OP_MUL = 4'b0001,
        OP_SUB = 4'b0010,
        OP_ADD = 4'b0011,
        OP_OR  = 4'b0100,
        OP_AND = 4'b0101,
        OP_NE  = 4'b0110,
        OP_GT  = 4'b0111,
        OP_LT  = 4'b1000
    } alu_op_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_DONE
    } alu_state_t;

    // Compares return 0 when the condition holds, so `zero` is the branch-taken flag.
    localparam logic CMP_TRUE  = 1'b0;
    localparam logic CMP_FALSE = 1'b1;

    // Mode bit of the shared iterative unit.
    localparam logic MODE_MUL = 1'b0;
    localparam logic MODE_DIV = 1'b1;

    function automatic logic cmp_result(input logic cond);
        return cond ? CMP_TRUE : CMP_FALSE;
    endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Radix-2 iterative multiply / restoring divide sharing one {hi, lo} shift
// register. `hi`/`lo` present the value the register takes at the current
// edge, so the owner can capture the final result on the edge that performs
// the last iteration (`last` high).
module alu_muldiv_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             last,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic [WIDTH-1:0] opnd_q;
    logic             mode_q;

    logic [WIDTH:0]   add_sum;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   trial;
    logic             no_borrow;
    logic [WIDTH-1:0] hi_step;
    logic [WIDTH-1:0] lo_step;

    // Iteration counter: loaded with WIDTH, counts down to 0 one bit per cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= CNT_W'(WIDTH);
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    // Shift register and operand hold; control (cnt_q) alone gates activity.
    // NOTE: datapath registers carry no reset: nothing reads them until a load
    // has written them, and keeping them out of the reset tree is cheaper.
    always_ff @(posedge clk) begin
        if (load) begin
            hi_q   <= '0;
            lo_q   <= a;
            opnd_q <= b;
            mode_q <= mode;
        end else if (cnt_q != '0) begin
            hi_q <= hi_step;
            lo_q <= lo_step;
        end
    end

    // One iteration step for the active mode.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // can leave it unassigned and infer a latch.
        hi_step = hi_q;
        lo_step = lo_q;

        // Multiply: add multiplicand when multiplier LSB is set, shift right.
        add_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);

        // Divide: shift {rem, quot} left, trial-subtract divisor. rem_sh is
        // below 2*b, so the top bit of trial is exactly the borrow.
        rem_sh    = {hi_q, lo_q[WIDTH-1]};
        trial     = rem_sh - {1'b0, opnd_q};
        no_borrow = ~trial[WIDTH];

        if (mode_q == MODE_DIV) begin
            hi_step = no_borrow ? trial[WIDTH-1:0] : rem_sh[WIDTH-1:0];
            lo_step = {lo_q[WIDTH-2:0], no_borrow};
        end else begin
            hi_step = add_sum[WIDTH:1];
            lo_step = {add_sum[0], lo_q[WIDTH-1:1]};
        end
    end

    assign last = (cnt_q == CNT_W'(1));
    assign hi   = hi_step;
    assign lo   = lo_step;

endmodule

// File: rtl/alu_multicycle.sv
// Clocked EX-stage ALU with valid/ready handshake. Single-cycle ops and
// divide-by-zero complete at the accept edge; MUL/DIV run WIDTH iterations
// on the shared alu_muldiv_iter unit. Results are held until the next
// completion.
module alu_multicycle
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_control,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             zero,
    output logic             div_by_zero,
    output logic             busy
);

    alu_state_t       state_q;
    alu_state_t       state_d;

    logic [WIDTH-1:0] alu_res;
    logic             iter_load;
    logic             iter_mode;
    logic             iter_last;
    logic [WIDTH-1:0] iter_hi;
    logic [WIDTH-1:0] iter_lo;

    logic             cap_en;
    logic [WIDTH-1:0] cap_result;
    logic [WIDTH-1:0] cap_hi;
    logic             cap_dbz;

    logic [WIDTH-1:0] result_q;
    logic [WIDTH-1:0] result_hi_q;
    logic             zero_q;
    logic             dbz_q;

    alu_muldiv_iter #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_iter (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (iter_load),
        .mode  (iter_mode),
        .a     (in_a),
        .b     (in_b),
        .last  (iter_last),
        .hi    (iter_hi),
        .lo    (iter_lo)
    );

    // Single-cycle datapath; MUL/DIV and invalid opcodes fall to 0 here.
    always_comb begin
        alu_res = '0;
        case (alu_control)
            OP_SUB:  alu_res = in_a - in_b;
            OP_ADD:  alu_res = in_a + in_b;
            OP_OR:   alu_res = in_a | in_b;
            OP_AND:  alu_res = in_a & in_b;
            OP_NE:   alu_res = {{(WIDTH-1){1'b0}}, cmp_result(in_a != in_b)};
            OP_GT:   alu_res = {{(WIDTH-1){1'b0}}, cmp_result(in_a > in_b)};
            OP_LT:   alu_res = {{(WIDTH-1){1'b0}}, cmp_result(in_a < in_b)};
            default: alu_res = '0;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every
            // register samples pre-edge values regardless of block order.
            state_q <= state_d;
        end
    end

    // Next state, iterative-unit load and output-register capture select.
    always_comb begin
        state_d    = state_q;
        iter_load  = 1'b0;
        iter_mode  = MODE_MUL;
        cap_en     = 1'b0;
        cap_result = alu_res;
        cap_hi     = '0;
        cap_dbz    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    if (alu_control == OP_MUL) begin
                        state_d   = ST_MUL;
                        iter_load = 1'b1;
                        iter_mode = MODE_MUL;
                    end else if (alu_control == OP_DIV && in_b != '0) begin
                        state_d   = ST_DIV;
                        iter_load = 1'b1;
                        iter_mode = MODE_DIV;
                    end else if (alu_control == OP_DIV) begin
                        state_d    = ST_DONE;
                        cap_en     = 1'b1;
                        cap_result = '1;
                        cap_hi     = in_a;
                        cap_dbz    = 1'b1;
                    end else begin
                        state_d = ST_DONE;
                        cap_en  = 1'b1;
                    end
                end
            end
            ST_MUL, ST_DIV: begin
                if (iter_last) begin
                    state_d    = ST_DONE;
                    cap_en     = 1'b1;
                    cap_result = iter_lo;
                    cap_hi     = iter_hi;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output registers: written only on the edge that enters DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q    <= '0;
            result_hi_q <= '0;
            zero_q      <= 1'b1;
            dbz_q       <= 1'b0;
        end else if (cap_en) begin
            result_q    <= cap_result;
            result_hi_q <= cap_hi;
            zero_q      <= (cap_result == '0);
            dbz_q       <= cap_dbz;
        end
    end

    assign result      = result_q;
    assign result_hi   = result_hi_q;
    assign zero        = zero_q;
    assign div_by_zero = dbz_q;

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q == ST_MUL) || (state_q == ST_DIV);

endmodule

// File: tb/tb_alu_multicycle.sv
// Self-checking bench for alu_multicycle: directed cases plus randomized
// operations compared against an arithmetic reference model.
module tb_alu_multicycle;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   alu_control;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic [W-1:0] result_hi;
    logic         zero;
    logic         div_by_zero;
    logic         busy;

    int errors = 0;
    int checks = 0;

    alu_multicycle #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .alu_control (alu_control),
        .in_a        (in_a),
        .in_b        (in_b),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result      (result),
        .result_hi   (result_hi),
        .zero        (zero),
        .div_by_zero (div_by_zero),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Reference: plain unsigned arithmetic. done_edges = edges after accept
    // until out_valid rises (0 for single-cycle ops, W for iterative ones).
    function automatic void ref_model(input logic [3:0] op, input logic [W-1:0] a,
                                      input logic [W-1:0] b, output logic [W-1:0] r,
                                      output logic [W-1:0] h, output logic dz,
                                      output int done_edges);
        logic [2*W-1:0] p;
        r = '0; h = '0; dz = 1'b0; done_edges = 0;
        case (op)
            4'd0: begin
                if (b == '0) begin r = '1; h = a; dz = 1'b1; end
                else begin r = a / b; h = a % b; done_edges = W; end
            end
            4'd1: begin
                p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
                r = p[W-1:0]; h = p[2*W-1:W]; done_edges = W;
            end
            4'd2: r = a - b;
            4'd3: r = a + b;
            4'd4: r = a | b;
            4'd5: r = a & b;
            4'd6: r = (a != b) ? '0 : W'(1);
            4'd7: r = (a > b)  ? '0 : W'(1);
            4'd8: r = (a < b)  ? '0 : W'(1);
            default: r = '0;
        endcase
    endfunction

    // Issue one op with out_ready=1; returns at the negedge where out_valid
    // is first seen, with the edge count after accept and busy cycles seen.
    task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          output int edges, output int busy_cycles);
        int guard;
        @(negedge clk);
        alu_control = op; in_a = a; in_b = b; in_valid = 1'b1; out_ready = 1'b1;
        guard = 0;
        while (!in_ready && guard < 100) begin @(negedge clk); guard++; end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL accept_timeout: in_ready=%0b required 1", in_ready);
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        edges = 0; busy_cycles = 0;
        while (!out_valid && edges < 100) begin
            if (busy) busy_cycles++;
            @(negedge clk);
            edges++;
        end
        checks++;
        if (out_valid !== 1'b1) begin
            errors++; $display("FAIL done_timeout: out_valid=%0b required 1", out_valid);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        alu_control = '0; in_a = '0; in_b = '0;
        #12;
        checks++;
        if ({out_valid, busy, in_ready, zero, div_by_zero} !== 5'b00110 ||
            result !== '0 || result_hi !== '0) begin
            errors++;
            $display("FAIL reset_values: ov=%0b busy=%0b ir=%0b z=%0b dbz=%0b r=%h hi=%h required 0 0 1 1 0 0 0",
                     out_valid, busy, in_ready, zero, div_by_zero, result, result_hi);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_add();
        int e, bc;
        run_op(4'd3, 32'hFFFF_FFFF, 32'd2, e, bc);
        checks++;
        if (e !== 0 || result !== 32'h1 || zero !== 1'b0 || result_hi !== '0) begin
            errors++;
            $display("FAIL add_wrap: edges=%0d r=%h z=%0b hi=%h required 0 00000001 0 0",
                     e, result, zero, result_hi);
        end
    endtask

    task automatic test_mul();
        int e, bc;
        run_op(4'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, e, bc);
        checks++;
        if (bc !== 32 || e !== 32 || result !== 32'h1 || result_hi !== 32'hFFFF_FFFE) begin
            errors++;
            $display("FAIL mul_max: busy=%0d edges=%0d r=%h hi=%h required 32 32 00000001 fffffffe",
                     bc, e, result, result_hi);
        end
    endtask

    task automatic test_div();
        int e, bc;
        run_op(4'd0, 32'd100, 32'd7, e, bc);
        checks++;
        if (e !== 32 || result !== 32'd14 || result_hi !== 32'd2 || div_by_zero !== 1'b0) begin
            errors++;
            $display("FAIL div_100_7: edges=%0d r=%0d hi=%0d dbz=%0b required 32 14 2 0",
                     e, result, result_hi, div_by_zero);
        end
        run_op(4'd0, 32'd5, 32'd0, e, bc);
        checks++;
        if (e !== 0 || bc !== 0 || result !== 32'hFFFF_FFFF || result_hi !== 32'd5 ||
            div_by_zero !== 1'b1) begin
            errors++;
            $display("FAIL div_by_zero: edges=%0d busy=%0d r=%h hi=%0d dbz=%0b required 0 0 ffffffff 5 1",
                     e, bc, result, result_hi, div_by_zero);
        end
    endtask

    task automatic test_compares();
        logic [3:0]   ops  [4] = '{4'd6, 4'd7, 4'd8, 4'd15};
        logic [W-1:0] as   [4] = '{32'd3, 32'd9, 32'd9, 32'd123};
        logic [W-1:0] bs   [4] = '{32'd3, 32'd3, 32'd3, 32'd45};
        logic [W-1:0] exps [4] = '{32'd1, 32'd0, 32'd1, 32'd0};
        int e, bc;
        for (int i = 0; i < 4; i++) begin
            run_op(ops[i], as[i], bs[i], e, bc);
            checks++;
            if (result !== exps[i] || zero !== (exps[i] == '0) || result_hi !== '0 ||
                div_by_zero !== 1'b0 || e !== 0) begin
                errors++;
                $display("FAIL compare_op%0d: r=%0d z=%0b hi=%0d dbz=%0b edges=%0d required r=%0d z=%0b hi=0 dbz=0 edges=0",
                         ops[i], result, zero, result_hi, div_by_zero, e, exps[i], exps[i] == '0);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] a, b, x, y, er, eh;
        logic         edz;
        int           ee, guard;
        a = $urandom; b = $urandom; x = $urandom; y = $urandom;
        ref_model(4'd1, a, b, er, eh, edz, ee);
        @(negedge clk);
        alu_control = 4'd1; in_a = a; in_b = b; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        // Next request held from now on; must wait for the handshake.
        alu_control = 4'd3; in_a = x; in_b = y;
        guard = 0;
        while (!out_valid && guard < 100) begin @(negedge clk); guard++; end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== er || result_hi !== eh ||
                zero !== (er == '0)) begin
                errors++;
                $display("FAIL bp_hold%0d: ov=%0b ir=%0b r=%h hi=%h required 1 0 %h %h",
                         i, out_valid, in_ready, result, result_hi, er, eh);
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== er) begin
            errors++;
            $display("FAIL bp_after_handshake: ir=%0b ov=%0b r=%h required 1 0 %h",
                     in_ready, out_valid, result, er);
        end
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || result !== x + y || result_hi !== '0) begin
            errors++;
            $display("FAIL bp_next_op: ov=%0b r=%h hi=%h required 1 %h 0",
                     out_valid, result, result_hi, x + y);
        end
    endtask

    task automatic test_reset_mid_div();
        int e, bc, stray;
        @(negedge clk);
        alu_control = 4'd0; in_a = $urandom | 32'h8000_0000; in_b = $urandom_range(3, 1000);
        in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL rst_div_running: busy=%0b required 1", busy);
        end
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, busy, in_ready, zero, div_by_zero} !== 5'b00110 ||
            result !== '0 || result_hi !== '0) begin
            errors++;
            $display("FAIL rst_mid_div: ov=%0b busy=%0b ir=%0b z=%0b dbz=%0b r=%h hi=%h required 0 0 1 1 0 0 0",
                     out_valid, busy, in_ready, zero, div_by_zero, result, result_hi);
        end
        @(negedge clk);
        rst_n = 1'b1;
        stray = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid || busy) stray++;
        end
        checks++;
        if (stray !== 0) begin
            errors++; $display("FAIL rst_stale_completion: active_cycles=%0d required 0", stray);
        end
        run_op(4'd3, 32'd1, 32'd1, e, bc);
        checks++;
        if (result !== 32'd2 || result_hi !== '0 || div_by_zero !== 1'b0 || e !== 0) begin
            errors++;
            $display("FAIL rst_then_add: r=%0d hi=%0d dbz=%0b edges=%0d required 2 0 0 0",
                     result, result_hi, div_by_zero, e);
        end
    endtask

    task automatic test_random();
        logic [3:0]   op;
        logic [W-1:0] a, b, er, eh;
        logic         edz;
        int           ee, e, bc;
        for (int n = 0; n < 40; n++) begin
            op = 4'($urandom_range(0, 15));
            a  = $urandom;
            case ($urandom_range(0, 7))
                0:       b = '0;
                1:       b = W'($urandom_range(1, 15));
                2:       b = a;
                default: b = $urandom;
            endcase
            if (n < 9) op = 4'(n);
            ref_model(op, a, b, er, eh, edz, ee);
            run_op(op, a, b, e, bc);
            checks++;
            if (result !== er || result_hi !== eh || zero !== (er == '0) ||
                div_by_zero !== edz || e !== ee) begin
                errors++;
                $display("FAIL random%0d op=%0d a=%h b=%h: r=%h hi=%h z=%0b dbz=%0b edges=%0d required %h %h %0b %0b %0d",
                         n, op, a, b, result, result_hi, zero, div_by_zero, e,
                         er, eh, er == '0, edz, ee);
            end
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_mul();
        test_div();
        test_compares();
        test_backpressure();
        test_reset_mid_div();
        test_random();
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
